// File: rtl/temporizador_ctrl.sv
// Two-digit BCD countdown timer with load, start/pause and prescaled tick.
// Counts from the preset down to 00, then parks in FIM until the next load.
module temporizador_ctrl #(
    parameter int TICKS_POR_PASSO = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       botao_carga,
    input  logic       botao_inicia,
    input  logic       tick,
    input  logic [3:0] preset_unid,
    input  logic [1:0] preset_dez,
    output logic [3:0] unid,
    output logic [1:0] dez,
    output logic       rodando,
    output logic       fim,
    output logic       erro_preset
);

    typedef enum logic [2:0] {
        OCIOSO,
        CARREGADO,
        CONTANDO,
        PAUSADO,
        FIM
    } estado_t;

    localparam logic [7:0] PRESC_MAX = 8'(TICKS_POR_PASSO - 1);

    estado_t    estado;
    logic [7:0] presc;
    logic       inicia_ant;
    logic       inicia_borda;
    logic       carga_ok;
    logic       zerado;
    logic       chega_zero;
    logic [3:0] unid_dec;
    logic [1:0] dez_dec;

    assign inicia_borda = botao_inicia & ~inicia_ant;
    assign carga_ok     = (preset_unid <= 4'd9);
    assign zerado       = (unid == 4'd0) && (dez == 2'd0);
    assign chega_zero   = (unid_dec == 4'd0) && (dez_dec == 2'd0);

    // BCD decrement with borrow from the tens digit
    always_comb begin
        unid_dec = unid - 4'd1;
        dez_dec  = dez;
        if (unid == 4'd0) begin
            unid_dec = 4'd9;
            dez_dec  = dez - 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado      <= OCIOSO;
            unid        <= 4'd0;
            dez         <= 2'd0;
            rodando     <= 1'b0;
            fim         <= 1'b0;
            erro_preset <= 1'b0;
            presc       <= 8'd0;
            inicia_ant  <= 1'b1;
        end else begin
            inicia_ant <= botao_inicia;
            if (botao_carga) begin
                if (carga_ok) begin
                    estado      <= CARREGADO;
                    unid        <= preset_unid;
                    dez         <= preset_dez;
                    rodando     <= 1'b0;
                    fim         <= 1'b0;
                    erro_preset <= 1'b0;
                    presc       <= 8'd0;
                end else begin
                    erro_preset <= 1'b1;
                end
            end else begin
                unique case (estado)
                    CARREGADO: begin
                        if (inicia_borda) begin
                            if (zerado) begin
                                estado <= FIM;
                                fim    <= 1'b1;
                            end else begin
                                estado  <= CONTANDO;
                                rodando <= 1'b1;
                            end
                        end
                    end
                    CONTANDO: begin
                        if (inicia_borda) begin
                            estado  <= PAUSADO;
                            rodando <= 1'b0;
                        end else if (tick) begin
                            if (presc == PRESC_MAX) begin
                                presc <= 8'd0;
                                unid  <= unid_dec;
                                dez   <= dez_dec;
                                if (chega_zero) begin
                                    estado  <= FIM;
                                    fim     <= 1'b1;
                                    rodando <= 1'b0;
                                end
                            end else begin
                                presc <= presc + 8'd1;
                            end
                        end
                    end
                    PAUSADO: begin
                        if (inicia_borda) begin
                            estado  <= CONTANDO;
                            rodando <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_temporizador_ctrl.sv
// Bench for temporizador_ctrl: prescale 1 and prescale 3 instances share
// stimulus; a count-level model is compared every cycle.
module tb_temporizador_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       botao_carga;
    logic       botao_inicia;
    logic       tick;
    logic [3:0] preset_unid;
    logic [1:0] preset_dez;

    logic [3:0] unid0, unid3;
    logic [1:0] dez0, dez3;
    logic       rod0, rod3, fim0, fim3, err0, err3;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_PAUS = 3;
    localparam int M_END  = 4;

    int m_cnt[2];
    int m_presc[2];
    int m_mode[2];
    bit m_fim[2];
    bit m_err[2];
    bit m_prev[2];

    always #5 clock = ~clock;

    temporizador_ctrl #(.TICKS_POR_PASSO(1)) u0 (
        .clock(clock), .reset(reset), .botao_carga(botao_carga),
        .botao_inicia(botao_inicia), .tick(tick),
        .preset_unid(preset_unid), .preset_dez(preset_dez),
        .unid(unid0), .dez(dez0), .rodando(rod0), .fim(fim0),
        .erro_preset(err0)
    );

    temporizador_ctrl #(.TICKS_POR_PASSO(3)) u3 (
        .clock(clock), .reset(reset), .botao_carga(botao_carga),
        .botao_inicia(botao_inicia), .tick(tick),
        .preset_unid(preset_unid), .preset_dez(preset_dez),
        .unid(unid3), .dez(dez3), .rodando(rod3), .fim(fim3),
        .erro_preset(err3)
    );

    task automatic model_step(input int k, input int t);
        bit e;
        if (!reset) begin
            m_mode[k]  = M_IDLE;
            m_cnt[k]   = 0;
            m_presc[k] = 0;
            m_fim[k]   = 0;
            m_err[k]   = 0;
            m_prev[k]  = 1;
        end else begin
            e = botao_inicia && !m_prev[k];
            m_prev[k] = botao_inicia;
            if (botao_carga) begin
                if (preset_unid <= 9) begin
                    m_cnt[k]   = int'(preset_dez) * 10 + int'(preset_unid);
                    m_mode[k]  = M_LOAD;
                    m_presc[k] = 0;
                    m_fim[k]   = 0;
                    m_err[k]   = 0;
                end else begin
                    m_err[k] = 1;
                end
            end else if (m_mode[k] == M_LOAD) begin
                if (e) begin
                    if (m_cnt[k] == 0) begin
                        m_mode[k] = M_END;
                        m_fim[k]  = 1;
                    end else begin
                        m_mode[k] = M_RUN;
                    end
                end
            end else if (m_mode[k] == M_RUN) begin
                if (e) begin
                    m_mode[k] = M_PAUS;
                end else if (tick) begin
                    m_presc[k] = m_presc[k] + 1;
                    if (m_presc[k] == t) begin
                        m_presc[k] = 0;
                        m_cnt[k]   = m_cnt[k] - 1;
                        if (m_cnt[k] == 0) begin
                            m_mode[k] = M_END;
                            m_fim[k]  = 1;
                        end
                    end
                end
            end else if (m_mode[k] == M_PAUS) begin
                if (e) m_mode[k] = M_RUN;
            end
        end
    endtask

    function automatic logic [8:0] expv(input int k);
        logic [3:0] u;
        logic [1:0] d;
        u = 4'(m_cnt[k] % 10);
        d = 2'(m_cnt[k] / 10);
        return {m_mode[k] == M_RUN, m_fim[k], m_err[k], d, u};
    endfunction

    function automatic int digits(input logic [1:0] d, input logic [3:0] u);
        return int'(d) * 10 + int'(u);
    endfunction

    task automatic cmp9(input string name, input logic [8:0] got,
                        input logic [8:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got {rod,fim,err,dez,unid}=%b required %b",
                     name, $time, got, exp);
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d required %0d",
                     name, $time, got, exp);
        end
    endtask

    initial begin
        @(posedge clock);
        forever begin
            model_step(0, 1);
            model_step(1, 3);
            #1;
            cmp9("model_u0", {rod0, fim0, err0, dez0, unid0}, expv(0));
            cmp9("model_u3", {rod3, fim3, err3, dez3, unid3}, expv(1));
            @(posedge clock);
        end
    end

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic load(input logic [1:0] d, input logic [3:0] u);
        botao_carga = 1'b1;
        preset_dez  = d;
        preset_unid = u;
        cyc();
        botao_carga = 1'b0;
    endtask

    task automatic press();
        botao_inicia = 1'b1;
        cyc();
        botao_inicia = 1'b0;
        cyc();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            cyc();
        end
        tick = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        botao_carga  = 1'b0;
        botao_inicia = 1'b0;
        tick         = 1'b0;
        preset_unid  = 4'd0;
        preset_dez   = 2'd0;
        cyc();
        cyc();
        chk("reset_u0", int'({rod0, fim0, err0, dez0, unid0}), 0);
        chk("reset_u3", int'({rod3, fim3, err3, dez3, unid3}), 0);
        reset = 1'b1;
        cyc();

        load(2'd2, 4'd5);
        chk("load25", digits(dez0, unid0), 25);
        chk("load25_rod", int'(rod0), 0);
        press();
        chk("start_rod", int'(rod0), 1);
        for (int i = 1; i <= 25; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            if (i == 5)  chk("cnt20", digits(dez0, unid0), 20);
            if (i == 6)  chk("borrow19", digits(dez0, unid0), 19);
            if (i == 15) chk("cnt10", digits(dez0, unid0), 10);
            if (i == 16) chk("borrow09", digits(dez0, unid0), 9);
            if (i == 24) chk("cnt01_fim", int'(fim0), 0);
            if (i == 25) begin
                chk("cnt00", digits(dez0, unid0), 0);
                chk("fim_set", int'(fim0), 1);
                chk("fim_rod", int'(rod0), 0);
            end
        end
        ticks(3);
        chk("no_wrap", digits(dez0, unid0), 0);
        chk("fim_hold", int'(fim0), 1);

        load(2'd1, 4'd7);
        load(2'd0, 4'd12);
        chk("bad_err", int'(err0), 1);
        chk("bad_keep17", digits(dez0, unid0), 17);
        press();
        chk("bad_state_kept", int'(rod0), 1);
        chk("err_sticky", int'(err0), 1);
        load(2'd0, 4'd3);
        chk("good_err", int'(err0), 0);
        chk("good_03", digits(dez0, unid0), 3);

        load(2'd1, 4'd4);
        press();
        chk("p_run", int'(rod0), 1);
        press();
        chk("p_paused", int'(rod0), 0);
        ticks(5);
        chk("p_hold14", digits(dez0, unid0), 14);
        press();
        chk("p_resume", int'(rod0), 1);
        ticks(1);
        chk("p_13", digits(dez0, unid0), 13);

        load(2'd0, 4'd2);
        press();
        for (int i = 1; i <= 6; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            if (i == 2) chk("pre_t2", digits(dez3, unid3), 2);
            if (i == 3) chk("pre_t3", digits(dez3, unid3), 1);
            if (i == 5) chk("pre_t5", digits(dez3, unid3), 1);
            if (i == 6) begin
                chk("pre_t6", digits(dez3, unid3), 0);
                chk("pre_fim", int'(fim3), 1);
            end
        end

        load(2'd0, 4'd8);
        press();
        tick         = 1'b1;
        botao_inicia = 1'b1;
        cyc();
        tick         = 1'b0;
        botao_inicia = 1'b0;
        chk("tk_ed_rod", int'(rod0), 0);
        chk("tk_ed_08", digits(dez0, unid0), 8);
        cyc();
        press();
        chk("tk_ed_resume", int'(rod0), 1);
        botao_carga = 1'b1;
        preset_dez  = 2'd0;
        preset_unid = 4'd5;
        tick        = 1'b1;
        cyc();
        botao_carga = 1'b0;
        tick        = 1'b0;
        chk("load_wins", digits(dez0, unid0), 5);
        chk("load_wins_rod", int'(rod0), 0);

        load(2'd3, 4'd1);
        press();
        ticks(2);
        chk("r_31", digits(dez3, unid3), 31);
        chk("r_run", int'(rod3), 1);
        botao_inicia = 1'b1;
        reset        = 1'b0;
        cyc();
        chk("r_u0", int'({rod0, fim0, err0, dez0, unid0}), 0);
        chk("r_u3", int'({rod3, fim3, err3, dez3, unid3}), 0);
        reset       = 1'b1;
        botao_carga = 1'b1;
        preset_dez  = 2'd0;
        preset_unid = 4'd4;
        cyc();
        botao_carga = 1'b0;
        repeat (3) cyc();
        chk("r_nostart", int'(rod3), 0);
        chk("r_04", digits(dez3, unid3), 4);
        botao_inicia = 1'b0;
        cyc();
        press();
        chk("r_restart", int'(rod3), 1);
        ticks(3);
        chk("r_presc_clr", digits(dez3, unid3), 3);
        chk("r_u0_01", digits(dez0, unid0), 1);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
